causal_dilated_conv: RTL
========================

Name: causal_dilated_conv

Overview:
Depthwise 1D causal dilated convolution stage, kernel size 2, placed directly upstream of the 1x1 channel-mixing convolution in the WaveNet residual block. Per channel c: y[t] = w1[c]*x[t] + w0[c]*x[t-DILATION] + bias[c], rescaled and saturated to int8. Keeps a circular history buffer of DILATION past input vectors. Its output vector has the same packed int8 channel format the 1x1 stage takes as input.

Parameters:
CHANNELS, 256, number of int8 channels per sample vector
DILATION, 4, tap spacing in samples; history depth; >= 1
SHIFT, 0, arithmetic right shift applied to the accumulator before saturation; 0..7
IDX_W, 8, width of the channel index on the weight-write port; 2**IDX_W >= CHANNELS

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  x carries a valid sample
in_ready  output  1  block can accept a sample this cycle
x  input  CHANNELS*8  packed signed int8 sample; channel c at [8c+7:8c]
out_valid  output  1  y holds a valid result
out_ready  input  1  consumer accepts y this cycle
y  output  CHANNELS*8  packed signed int8 result, same layout as x
seq_clear  input  1  synchronous start-of-sequence; discards history
w_write  input  1  weight/bias write strobe
w_sel  input  2  0 = w0 (delayed tap), 1 = w1 (current tap), 2 = bias, 3 = ignored
w_index  input  IDX_W  target channel; indices >= CHANNELS are ignored
w_value  input  8  signed int8 value to write

Behaviour:
- Reset (reset=0, async): out_valid=0, y=0, wr_ptr=0, fill=0, all w0/w1/bias=0. in_ready=1 right after reset. History RAM contents are not reset; fill-based masking covers them.
- Handshake: in_ready = !out_valid | out_ready (combinational). Accept = in_valid & in_ready. Output is taken when out_valid & out_ready.
- Latency: 1 cycle. The sample accepted at edge N is on y with out_valid=1 after edge N. y and out_valid hold while out_valid & !out_ready.
- Full throughput: 1 sample/cycle with out_ready held at 1.
- On accept: xd = (fill == DILATION) ? hist[wr_ptr] : 0 (causal zero padding). hist[wr_ptr] <= x. wr_ptr <= (wr_ptr == DILATION-1) ? 0 : wr_ptr+1. fill saturates at DILATION.
- Without accept: out_valid <= out_valid & !out_ready; history, wr_ptr and fill are unchanged.
- Arithmetic per channel, all signed:
  - p0 = w0*xd and p1 = w1*x, 16b each.
  - acc = p0 + p1 + (bias <<< SHIFT), 18b minimum.
  - r = (acc + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >>> SHIFT, i.e. round half up.
  - y_c = clip(r, -128, 127).
- seq_clear: wr_ptr <= 0, fill <= 0. It does not touch the output register or the weights. If seq_clear and accept occur together, the accepted sample is the first of the new sequence: it uses xd=0, is written at ptr 0, and leaves wr_ptr=1, fill=1.
- Weight write: registered at the edge and used from the next accepted sample onward. A write in the same cycle as an accept does not affect that sample; the sample uses the old value.
- DILATION=1: single-entry history, wr_ptr stays 0.
- Reset asserted mid-stream: the in-flight output is lost, out_valid drops immediately, and history is treated as empty.

Decomposition:
- Shared package: int8/acc16/acc18 typedefs, W_SEL_W0/W1/BIAS constants, sat8 and round-shift helper functions (also used by the 1x1 and gated-activation stages).
- One sub-module, dilation_history: circular buffer with wr_ptr, fill counter, and read-before-write of the same address. The top level holds the weight registers, the per-channel MAC/saturate generate loop, and the output register/handshake.

Test Plan:
(All tests use CHANNELS=4, DILATION=2, SHIFT=0 unless stated.)
1. Reset: assert reset=0 mid-run -> out_valid=0, y=0, in_ready=1 at once; after release, first sample x0=10, w0=w1=1 -> y0=10 (zero history).
2. Streaming: w0=w1=1, bias=0, ch0 x=10,20,30,40 back-to-back, out_ready=1 -> y ch0 = 10,20,40,60, one per cycle, no bubbles.
3. Saturation: w1=127, w0=0, x=127 -> y=127; x=-128 -> y=-128; bias=-128 with x=0 -> y=-128.
4. Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, y stable. Release -> sequence identical to test 2, no drop or duplicate.
5. seq_clear together with the 3rd accept (x=30) -> y=30 (xd=0); next x=40 -> y=40; x=50 -> y=80.
6. Rounding with SHIFT=2, w1=1: acc=6 -> y=2; acc=-6 -> y=-1; acc=5 -> y=1. A weight write in the same cycle as an accept leaves that sample's result on the old weight.

Source files
------------

// File: rtl/causal_dilated_conv_pkg.sv
// Shared fixed-point types and helpers for the WaveNet residual-block stages.
package causal_dilated_conv_pkg;

  typedef logic signed [7:0]  int8_t;
  typedef logic signed [15:0] acc16_t;
  typedef logic signed [17:0] acc18_t;

  localparam logic [1:0] W_SEL_W0   = 2'd0;
  localparam logic [1:0] W_SEL_W1   = 2'd1;
  localparam logic [1:0] W_SEL_BIAS = 2'd2;

  // Arithmetic right shift with round-half-up; sh == 0 passes through.
  function automatic acc18_t round_shift(input acc18_t a, input int unsigned sh);
    acc18_t r;
    if (sh == 0) begin
      r = a;
    end else begin
      r = (a + (acc18_t'(1) <<< (sh - 1))) >>> sh;
    end
    return r;
  endfunction

  function automatic int8_t sat8(input acc18_t a);
    int8_t r;
    if (a > 18'sd127) begin
      r = 8'sd127;
    end else if (a < -18'sd128) begin
      r = -8'sd128;
    end else begin
      r = int8_t'(a[7:0]);
    end
    return r;
  endfunction

endpackage

// File: rtl/causal_dilated_conv_if.sv
// Sample stream, result stream and weight-write port of the dilated conv stage.
interface causal_dilated_conv_if #(
  parameter int unsigned CHANNELS = 256,
  parameter int unsigned IDX_W    = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [CHANNELS*8-1:0] x;
  logic                  out_valid;
  logic                  out_ready;
  logic [CHANNELS*8-1:0] y;
  logic                  seq_clear;
  logic                  w_write;
  logic [1:0]            w_sel;
  logic [IDX_W-1:0]      w_index;
  logic [7:0]            w_value;

  modport slave (
    input  in_valid, x, out_ready, seq_clear, w_write, w_sel, w_index, w_value,
    output in_ready, out_valid, y
  );

  modport master (
    output in_valid, x, out_ready, seq_clear, w_write, w_sel, w_index, w_value,
    input  in_ready, out_valid, y
  );
endinterface

// File: rtl/causal_dilated_conv_dilation_history.sv
// Circular buffer of the last DEPTH accepted samples; returns the sample DEPTH
// accepts old (zero until the buffer has filled since the last clear).
module causal_dilated_conv_dilation_history #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2048
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             accept,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FILL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, wr_addr;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              full;

  // A clear in the same cycle as an accept restarts the sequence at slot 0.
  assign wr_addr = clear ? '0 : wr_ptr_q;
  assign full    = (fill_q == FILL_W'(DEPTH)) && !clear;
  assign dout    = full ? mem[wr_addr] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    if (clear) begin
      wr_ptr_d = '0;
      fill_d   = '0;
    end
    if (accept) begin
      wr_ptr_d = (wr_addr == PTR_W'(DEPTH - 1)) ? '0 : wr_addr + 1'b1;
      if (fill_d != FILL_W'(DEPTH)) begin
        fill_d = fill_d + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Storage is deliberately unreset; fill masks stale entries.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_addr] <= din;
    end
  end

endmodule

// File: rtl/causal_dilated_conv.sv
// Depthwise causal dilated conv, kernel 2: y = w1*x[t] + w0*x[t-D] + bias, rescaled
// and saturated to int8, with a one-deep registered output stage.
module causal_dilated_conv
  import causal_dilated_conv_pkg::*;
#(
  parameter int unsigned CHANNELS = 256,
  parameter int unsigned DILATION = 4,
  parameter int unsigned SHIFT    = 0,
  parameter int unsigned IDX_W    = 8
) (
  input logic                  clk,
  input logic                  reset,
  causal_dilated_conv_if.slave bus
);
  logic                  accept;
  logic                  out_valid_q;
  logic [CHANNELS*8-1:0] y_q, y_d, xd;
  int8_t                 w0_q [CHANNELS];
  int8_t                 w1_q [CHANNELS];
  int8_t                 b_q  [CHANNELS];

  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;

  causal_dilated_conv_dilation_history #(
    .DEPTH (DILATION),
    .WIDTH (CHANNELS * 8)
  ) u_dilation_history (
    .clk    (clk),
    .reset  (reset),
    .accept (accept),
    .clear  (bus.seq_clear),
    .din    (bus.x),
    .dout   (xd)
  );

  // Out-of-range indices match no channel and are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        w0_q[c] <= '0;
        w1_q[c] <= '0;
        b_q[c]  <= '0;
      end
    end else if (bus.w_write) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (bus.w_index == IDX_W'(c)) begin
          case (bus.w_sel)
            W_SEL_W0:   w0_q[c] <= bus.w_value;
            W_SEL_W1:   w1_q[c] <= bus.w_value;
            W_SEL_BIAS: b_q[c]  <= bus.w_value;
            default:    ;
          endcase
        end
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    int8_t  xc, xdc;
    acc16_t p0, p1;
    acc18_t acc;

    assign xc  = bus.x[8*c +: 8];
    assign xdc = xd[8*c +: 8];
    assign p0  = acc16_t'(w0_q[c]) * acc16_t'(xdc);
    assign p1  = acc16_t'(w1_q[c]) * acc16_t'(xc);
    // Bias is pre-scaled so it lands at unit weight after the rescale.
    assign acc = acc18_t'(p0) + acc18_t'(p1) + (acc18_t'(b_q[c]) <<< SHIFT);
    assign y_d[8*c +: 8] = sat8(round_shift(acc, SHIFT));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      y_q         <= y_d;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule
